// File: rtl/tilt_position_ctrl.sv
// Tilt-driven position counter: debounces accelerometer tilt flags at the sample rate
// and steps a saturating position with an immediate first step and auto-repeat.
module tilt_position_ctrl #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int SAMPLE_HZ = 100,
   parameter int DEBOUNCE  = 4,
   parameter int REPEAT    = 10,
   parameter int POS_W     = 4,
   parameter int POS_MAX   = 15,
   parameter int POS_INIT  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             left,
   input  logic             right,
   input  logic             middle,
   input  logic             recenter,
   output logic [POS_W-1:0] pos,
   output logic [POS_MAX:0] led,
   output logic             at_min,
   output logic             at_max,
   output logic             step,
   output logic [1:0]       dir
);

   localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
   localparam int DIV_W      = $clog2(SAMPLE_DIV);
   localparam int DCNT_W     = $clog2(DEBOUNCE + 1);
   localparam int RCNT_W     = $clog2(REPEAT + 1);

   localparam logic [1:0] DIR_N = 2'b00;
   localparam logic [1:0] DIR_R = 2'b01;
   localparam logic [1:0] DIR_L = 2'b10;

   typedef enum logic [1:0] {IDLE = 2'b00, HOLD_L = 2'b01, HOLD_R = 2'b10} state_t;

   logic [DIV_W-1:0]  div_r;
   logic              tick_s;
   logic [1:0]        raw_s;
   logic [1:0]        cand_r, cand_nxt_s;
   logic [DCNT_W-1:0] dcnt_r, dcnt_nxt_s;
   logic              commit_s;
   state_t            state_r, state_nxt_s;
   logic [RCNT_W-1:0] rcnt_r, rcnt_nxt_s;
   logic [1:0]        dir_r, dir_nxt_s;
   logic              step_req_s, step_up_s;
   logic [POS_W-1:0]  pos_r, pos_nxt_s;
   logic              step_r, step_nxt_s;
   logic              unused_s;

   assign unused_s = middle;
   assign tick_s   = (div_r == DIV_W'(SAMPLE_DIV - 1));

   // Sample-rate divider
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r <= '0;
      end else if (tick_s) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Raw tilt decode; both or neither asserted means neutral
   always_comb begin
      raw_s = DIR_N;
      if (left && !right) begin
         raw_s = DIR_L;
      end else if (right && !left) begin
         raw_s = DIR_R;
      end else begin
         raw_s = DIR_N;
      end
   end

   // Debounce candidate tracking and commit detection
   always_comb begin
      cand_nxt_s = cand_r;
      dcnt_nxt_s = dcnt_r;
      if (tick_s) begin
         if (raw_s == cand_r) begin
            if (dcnt_r != DCNT_W'(DEBOUNCE)) begin
               dcnt_nxt_s = dcnt_r + DCNT_W'(1);
            end else begin
               dcnt_nxt_s = dcnt_r;
            end
         end else begin
            cand_nxt_s = raw_s;
            dcnt_nxt_s = DCNT_W'(1);
         end
      end else begin
         cand_nxt_s = cand_r;
      end
      commit_s = tick_s && (dcnt_nxt_s == DCNT_W'(DEBOUNCE)) && (cand_nxt_s != dir_r);
   end

   // Hold FSM: immediate step on commit, auto-repeat every REPEAT ticks
   always_comb begin
      state_nxt_s = state_r;
      rcnt_nxt_s  = rcnt_r;
      dir_nxt_s   = dir_r;
      step_req_s  = 1'b0;
      step_up_s   = 1'b0;
      if (commit_s) begin
         dir_nxt_s  = cand_nxt_s;
         rcnt_nxt_s = '0;
         case (cand_nxt_s)
            DIR_L: begin
               state_nxt_s = HOLD_L;
               step_req_s  = 1'b1;
            end
            DIR_R: begin
               state_nxt_s = HOLD_R;
               step_req_s  = 1'b1;
               step_up_s   = 1'b1;
            end
            default: state_nxt_s = IDLE;
         endcase
      end else if (tick_s) begin
         case (state_r)
            HOLD_L, HOLD_R: begin
               step_up_s = (state_r == HOLD_R);
               if (rcnt_r == RCNT_W'(REPEAT - 1)) begin
                  rcnt_nxt_s = '0;
                  step_req_s = 1'b1;
               end else begin
                  rcnt_nxt_s = rcnt_r + RCNT_W'(1);
               end
            end
            default: rcnt_nxt_s = rcnt_r;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Saturating position update; recenter wins and suppresses the step pulse
   always_comb begin
      pos_nxt_s  = pos_r;
      step_nxt_s = 1'b0;
      if (recenter) begin
         pos_nxt_s = POS_W'(POS_INIT);
      end else if (step_req_s) begin
         if (step_up_s) begin
            if (pos_r != POS_W'(POS_MAX)) begin
               pos_nxt_s  = pos_r + POS_W'(1);
               step_nxt_s = 1'b1;
            end else begin
               pos_nxt_s = pos_r;
            end
         end else if (pos_r != POS_W'(0)) begin
            pos_nxt_s  = pos_r - POS_W'(1);
            step_nxt_s = 1'b1;
         end else begin
            pos_nxt_s = pos_r;
         end
      end else begin
         pos_nxt_s = pos_r;
      end
   end

   // Control and position state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_r  <= DIR_N;
         dcnt_r  <= '0;
         state_r <= IDLE;
         rcnt_r  <= '0;
         dir_r   <= DIR_N;
         pos_r   <= POS_W'(POS_INIT);
         step_r  <= 1'b0;
      end else begin
         cand_r  <= cand_nxt_s;
         dcnt_r  <= dcnt_nxt_s;
         state_r <= state_nxt_s;
         rcnt_r  <= rcnt_nxt_s;
         dir_r   <= dir_nxt_s;
         pos_r   <= pos_nxt_s;
         step_r  <= step_nxt_s;
      end
   end

   assign pos    = pos_r;
   assign dir    = dir_r;
   assign step   = step_r;
   assign led    = {{POS_MAX{1'b0}}, 1'b1} << pos_r;
   assign at_min = (pos_r == POS_W'(0));
   assign at_max = (pos_r == POS_W'(POS_MAX));

endmodule

// File: tb/tb_tilt_position_ctrl.sv
// Scoreboard bench for tilt_position_ctrl: a tick-level reference model pushes the
// expected outputs of every clock; a negedge monitor pops and compares them.
module tb_tilt_position_ctrl;

   localparam int CLK_HZ    = 1000;
   localparam int SAMPLE_HZ = 100;
   localparam int SDIV      = 10;
   localparam int DEB       = 4;
   localparam int REP       = 10;
   localparam int POS_W     = 4;
   localparam int POS_MAX   = 15;
   localparam int POS_INIT  = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             left = 1'b0;
   logic             right = 1'b0;
   logic             middle = 1'b0;
   logic             recenter = 1'b0;
   logic [POS_W-1:0] pos;
   logic [POS_MAX:0] led;
   logic             at_min;
   logic             at_max;
   logic             step;
   logic [1:0]       dir;

   tilt_position_ctrl #(
      .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .DEBOUNCE(DEB), .REPEAT(REP),
      .POS_W(POS_W), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT)
   ) dut (
      .clk(clk), .rst(rst), .left(left), .right(right), .middle(middle),
      .recenter(recenter), .pos(pos), .led(led), .at_min(at_min),
      .at_max(at_max), .step(step), .dir(dir)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pos;
      int dir;
      int step;
      bit pin;
      int c_pos;
      int c_dir;
      int c_step;
   } exp_t;

   exp_t sq[$];
   int checks = 0;
   int errors = 0;

   // Reference model: direction codes 0 neutral, 1 right, 2 left
   int m_cyc, m_run_val, m_run_len, m_dir, m_since, m_pos;

   function automatic int decode(bit l, bit r);
      if (l && !r) return 2;
      if (r && !l) return 1;
      return 0;
   endfunction

   task automatic drive(bit rs, bit l, bit r, bit rc);
      exp_t e;
      bit   tick;
      bit   req;
      int   raw;
      int   np;
      int   st;
      rst = rs; left = l; right = r; recenter = rc; middle = !(l || r);
      st = 0;
      if (rs) begin
         m_cyc = 0; m_run_val = 0; m_run_len = 0; m_dir = 0; m_since = 0; m_pos = POS_INIT;
      end else begin
         tick = ((m_cyc % SDIV) == SDIV - 1);
         m_cyc++;
         req = 1'b0;
         if (tick) begin
            raw = decode(l, r);
            if (raw == m_run_val) m_run_len++;
            else begin m_run_val = raw; m_run_len = 1; end
            if (m_run_len == DEB && raw != m_dir) begin
               m_dir = raw; m_since = 0; req = (raw != 0);
            end else if (m_dir != 0) begin
               m_since++;
               req = ((m_since % REP) == 0);
            end
         end
         if (rc) m_pos = POS_INIT;
         else if (req) begin
            np = (m_dir == 1) ? ((m_pos < POS_MAX) ? m_pos + 1 : POS_MAX)
                              : ((m_pos > 0) ? m_pos - 1 : 0);
            st = (np != m_pos) ? 1 : 0;
            m_pos = np;
         end
      end
      e.pos = m_pos; e.dir = m_dir; e.step = st;
      e.pin = 1'b0; e.c_pos = 0; e.c_dir = 0; e.c_step = 0;
      sq.push_back(e);
   endtask

   task automatic pin(int p, int d, int s);
      exp_t e;
      e = sq.pop_back();
      e.pin = 1'b1; e.c_pos = p; e.c_dir = d; e.c_step = s;
      sq.push_back(e);
   endtask

   task automatic cyc(bit rs, bit l, bit r, bit rc);
      drive(rs, l, r, rc);
      @(negedge clk);
   endtask

   task automatic pcyc(bit rs, bit l, bit r, bit rc, int p, int d, int s);
      drive(rs, l, r, rc);
      pin(p, d, s);
      @(negedge clk);
   endtask

   task automatic run(bit l, bit r, int n);
      for (int i = 0; i < n; i++) cyc(1'b0, l, r, 1'b0);
   endtask

   task automatic chk(string name, int act, int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
      end
   endtask

   // Monitor: every clock presents outputs; compare against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (sq.size() > 0) begin
         e = sq.pop_front();
         chk("pos", int'(pos), e.pos);
         chk("dir", int'(dir), e.dir);
         chk("step", int'(step), e.step);
         chk("led", int'(led), 1 << e.pos);
         chk("at_min", int'(at_min), (e.pos == 0) ? 1 : 0);
         chk("at_max", int'(at_max), (e.pos == POS_MAX) ? 1 : 0);
         if (e.pin) begin
            chk("plan_pos", int'(pos), e.c_pos);
            chk("plan_dir", int'(dir), e.c_dir);
            chk("plan_step", int'(step), e.c_step);
         end
      end
   end

   initial begin
      bit l, r, rc, rs;
      int len;
      // Reset, then hold right: commit on tick 4, repeats at ticks 14 and 24
      pcyc(1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      run(1'b0, 1'b1, 39);
      pcyc(1'b0, 1'b0, 1'b1, 1'b0, 9, 1, 1);
      run(1'b0, 1'b1, 99);
      pcyc(1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 1);
      run(1'b0, 1'b1, 99);
      pcyc(1'b0, 1'b0, 1'b1, 1'b0, 11, 1, 1);

      // Three-tick glitch never commits
      pcyc(1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      run(1'b0, 1'b1, 30);
      run(1'b0, 1'b0, 100);
      pcyc(1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 0);

      // Both asserted is neutral; then left commits after four ticks
      pcyc(1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      run(1'b1, 1'b1, 200);
      run(1'b1, 1'b0, 39);
      pcyc(1'b0, 1'b1, 0, 1'b0, 7, 2, 1);

      // Long left hold saturates at zero without further steps
      run(1'b1, 1'b0, 2000);
      pcyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 0);

      // Recenter on a repeat-step cycle, then repeats resume; reset mid-hold
      pcyc(1'b1, 1'b0, 1'b0, 1'b0, 8, 0, 0);
      run(1'b0, 1'b1, 39);
      pcyc(1'b0, 1'b0, 1'b1, 1'b0, 9, 1, 1);
      run(1'b0, 1'b1, 99);
      pcyc(1'b0, 1'b0, 1'b1, 1'b1, 8, 1, 0);
      run(1'b0, 1'b1, 99);
      pcyc(1'b0, 1'b0, 1'b1, 1'b0, 9, 1, 1);
      run(1'b0, 1'b1, 50);
      pcyc(1'b1, 1'b0, 1'b1, 1'b0, 8, 0, 0);

      // Randomized segments of tilt, glitches, recenter and occasional reset
      for (int seg = 0; seg < 60; seg++) begin
         len = $urandom_range(5, 400);
         case ($urandom_range(0, 4))
            0: begin l = 1'b0; r = 1'b0; end
            1: begin l = 1'b1; r = 1'b0; end
            2: begin l = 1'b0; r = 1'b1; end
            3: begin l = 1'b1; r = 1'b1; end
            default: begin
               l = 1'($urandom_range(0, 1));
               r = 1'($urandom_range(0, 1));
               len = $urandom_range(1, 3) * SDIV;
            end
         endcase
         for (int i = 0; i < len; i++) begin
            rc = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 2999) == 0);
            cyc(rs, l, r, rc);
         end
      end

      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tilt_position_ctrl.md
# tilt_position_ctrl

Downstream consumer of the accelerometer SPI controller's `left`/`right`/`middle` flags. It samples the tilt flags at the accelerometer update rate and debounces them. It turns a sustained tilt into a saturating position counter with an immediate first step and auto-repeat. It drives the position value, a one-hot LED bar and bound flags for the board's display/game logic.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `SAMPLE_HZ`, 100, tilt sampling rate. `SAMPLE_DIV = CLK_HZ/SAMPLE_HZ` (integer, ≥2).
- `DEBOUNCE`, 4, consecutive identical samples (≥1) needed to commit a direction.
- `REPEAT`, 10, samples between auto-repeat steps while tilt is held (≥1).
- `POS_W`, 4, position width.
- `POS_MAX`, 15, upper position bound (≤ 2^POS_W−1). Lower bound is 0.
- `POS_INIT`, 8, reset/recenter position (≤ POS_MAX).

Ports:
- `clk  in  1` system clock.
- `rst  in  1` reset, synchronous, active-high.
- `left  in  1` tilt-left flag from the accelerometer controller.
- `right  in  1` tilt-right flag.
- `middle  in  1` neutral flag. Accepted but not used for decode.
- `recenter  in  1` synchronous request to load `POS_INIT`.
- `pos  out  POS_W` current position.
- `led  out  POS_MAX+1` one-hot, `led[pos]=1`.
- `at_min  out  1` `pos==0`.
- `at_max  out  1` `pos==POS_MAX`.
- `step  out  1` one-cycle pulse on every cycle `pos` actually changes by a step.
- `dir  out  2` committed direction: 00 neutral, 01 right, 10 left.

## Operation
- **Raw decode:** left&~right → L; right&~left → R; none or both → N. `middle` is ignored because both inputs can be asserted at once and its value adds nothing.
- **Sample tick:** a divider counts 0..SAMPLE_DIV−1. `tick` is high on the cycle the count equals SAMPLE_DIV−1. All debounce and FSM updates occur only on tick cycles.
- **Debounce:** registers `cand` (N at reset) and `dcnt` (0 at reset, saturates at DEBOUNCE).
  - On a tick with raw==cand: `dcnt++` (saturating).
  - On a tick with raw≠cand: `cand<=raw`, `dcnt<=1`.
  - A commit occurs on the tick where the new `dcnt` value reaches DEBOUNCE and `cand≠dir`. The commit sets `dir<=cand`.
  - With DEBOUNCE=1, every change commits on its first tick.
- **FSM:** states IDLE (dir N), HOLD_L, HOLD_R.
  - On a commit to L or R (from any state): enter HOLD_x, take one step immediately, clear `rcnt`.
  - On a commit to N: enter IDLE, no step.
  - In HOLD_x on a non-commit tick: `rcnt++`. When `rcnt==REPEAT−1`: step and `rcnt<=0`.
  - A direct L↔R reversal is a commit, so it steps immediately in the new direction.
- **Step:** L decrements `pos`, R increments it, saturating at 0 / POS_MAX.
  - A step at a bound leaves `pos` unchanged and does not assert `step`.
  - The FSM and `rcnt` still advance normally.
- **Recenter:** when `recenter=1` on any cycle, `pos<=POS_INIT`. This has priority over a step in the same cycle, and `step` is not asserted in that cycle. FSM, debounce and divider are unaffected.
- `led`, `at_min` and `at_max` are decoded combinationally from registered `pos`.

## Timing
- Reset values:
  - `pos=POS_INIT`, `dir=00`, `step=0`, FSM IDLE.
  - `cand=N`, `dcnt=0`, `rcnt=0`, divider 0.
  - Derived: `led=1<<POS_INIT`, `at_min=(POS_INIT==0)`, `at_max=(POS_INIT==POS_MAX)`.
- The first tick occurs SAMPLE_DIV cycles after the first cycle with `rst=0`.
- Commit latency: a raw value stable from before tick k commits on tick k+DEBOUNCE−1. `pos`, `dir` and `step` are visible the cycle after that tick edge.
- `step` is high for exactly one clock, aligned with the first cycle the new `pos` is visible.
- Repeat period in HOLD is REPEAT ticks (REPEAT·SAMPLE_DIV clocks).
- Reset asserted mid-hold or mid-debounce returns all state to reset values on the next edge. No step is generated by reset.
- Input glitches shorter than DEBOUNCE ticks never change `dir`. A glitch also restarts the count for the value it interrupted.

## Test plan
Bench parameters: CLK_HZ=1000, SAMPLE_HZ=100 (SAMPLE_DIV=10), DEBOUNCE=4, REPEAT=10, POS_W=4, POS_MAX=15, POS_INIT=8.
- Reset → `pos=8`, `led=16'h0100`, `dir=00`, `step=0`. The first tick occurs on clock 10 after reset release.
- Hold right=1 from reset → commit on tick 4: `pos=9`, one `step` pulse, `dir=01`. Then `pos=10` at tick 14 and `pos=11` at tick 24.
- right=1 for 3 ticks, then N → `dir` stays 00, `pos` stays 8, no `step`.
- left=right=1 held 20 ticks → treated as N, no movement. Then left only → `pos=7` at 4 ticks.
- Hold left for 200 ticks → `pos` reaches 0, `at_min=1`. Further repeat ticks give no `step` and `pos` stays 0.
- In HOLD_R with `recenter` asserted on a repeat-step cycle → `pos=8`, no `step`. Repeats continue 10 ticks later to `pos=9`. A reset pulse mid-hold returns to `pos=8`, `dir=00`.
